// File: rtl/mem_port_arbiter_if.sv
// Valid/ready memory port bundle shared by requesters and the memory slave.
// The requester drives valid/addr/wdata/wstrb and receives rdata/ready;
// the responder does the opposite. wstrb == 0 marks a read.
interface mem_port_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output valid, addr, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of one valid/ready memory slave (SDRAM controller).
// Master 0 is the CPU window, master 1 the DMA/video fetch path. Arbitration is
// decided from a registered IDLE state; a grant is held until the slave answers
// or the per-transaction watchdog forces an error completion through ERR.
module mem_port_arbiter #(
    parameter int          PRIORITY_MODE  = 0,      // 0 round-robin, 1 fixed (m0 wins ties)
    parameter int          TIMEOUT_CYCLES = 4096,   // 0 disables the watchdog
    parameter logic [31:0] ERR_RDATA      = 32'h0
) (
    input  logic               clk,
    input  logic               resetn,
    mem_port_arbiter_if.slave  m0,
    mem_port_arbiter_if.slave  m1,
    mem_port_arbiter_if.master s,
    output logic [1:0]         grant,
    output logic               timeout_flag,
    output logic               timeout_master,
    input  logic               timeout_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int               CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam bit               FIXED_PRIO = (PRIORITY_MODE != 0);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_owner;          // master currently granted (also the one in ERR)
    logic             w_next_owner;
    logic             r_last_grant;     // master served most recently, for round-robin
    logic [CNT_W-1:0] r_wdog_cnt;
    logic             r_timeout_flag;
    logic             r_timeout_master;

    logic             w_gnt_active;
    logic             w_wdog_expire;
    logic             w_done;

    assign w_gnt_active  = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    // A slave answer on the last watchdog cycle still counts as a normal completion.
    assign w_wdog_expire = WDOG_EN && w_gnt_active && !s.ready && (r_wdog_cnt == WDOG_LAST);
    assign w_done        = (w_gnt_active && s.ready) || (r_state == ST_ERR);

    assign timeout_flag   = r_timeout_flag;
    assign timeout_master = r_timeout_master;

    // State and owner register; last_grant follows every completion (normal or forced)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            if (w_done) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // Watchdog: zero outside a grant, counts grant cycles without a slave answer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wdog_cnt <= '0;
        end else if (!w_gnt_active) begin
            r_wdog_cnt <= '0;
        end else if (!s.ready) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    // Sticky timeout status; a forced completion beats a simultaneous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timeout_flag   <= 1'b0;
            r_timeout_master <= 1'b0;
        end else if (r_state == ST_ERR) begin
            r_timeout_flag   <= 1'b1;
            r_timeout_master <= r_owner;
        end else if (timeout_clr) begin
            r_timeout_flag   <= 1'b0;
        end
    end

    // Next state: arbitrate in IDLE, hold grant until slave answer or watchdog expiry
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_next_state = r_state;
        w_next_owner = r_owner;
        case (r_state)
            ST_IDLE: begin
                // m0 wins when alone, under fixed priority, or when m1 was served last.
                if (m0.valid && (!m1.valid || FIXED_PRIO || r_last_grant)) begin
                    w_next_state = ST_GNT0;
                    w_next_owner = 1'b0;
                end else if (m1.valid) begin
                    w_next_state = ST_GNT1;
                    w_next_owner = 1'b1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (s.ready) begin
                    w_next_state = ST_IDLE;
                end else if (w_wdog_expire) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_ERR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Port muxing: slave sees only the owner; completions return only to the owner
    always_comb begin
        grant    = 2'b00;
        s.valid  = 1'b0;
        s.addr   = '0;
        s.wdata  = '0;
        s.wstrb  = '0;
        m0.ready = 1'b0;
        m0.rdata = '0;
        m1.ready = 1'b0;
        m1.rdata = '0;
        if (r_state != ST_IDLE) begin
            grant = r_owner ? 2'b10 : 2'b01;
        end
        if (w_gnt_active) begin
            if (r_owner) begin
                s.valid  = m1.valid;
                s.addr   = m1.addr;
                s.wdata  = m1.wdata;
                s.wstrb  = m1.wstrb;
                m1.ready = s.ready;
                m1.rdata = s.rdata;
            end else begin
                s.valid  = m0.valid;
                s.addr   = m0.addr;
                s.wdata  = m0.wdata;
                s.wstrb  = m0.wstrb;
                m0.ready = s.ready;
                m0.rdata = s.rdata;
            end
        end else if (r_state == ST_ERR) begin
            if (r_owner) begin
                m1.ready = 1'b1;
                m1.rdata = ERR_RDATA;
            end else begin
                m0.ready = 1'b1;
                m0.rdata = ERR_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is round-robin, instance 1 fixed
// priority, both with an 8-cycle watchdog. Directed scenarios use constant
// expectations; the random scenario is checked against a transaction-level
// model of ownership, grant age and the sticky timeout status.
module tb_mem_port_arbiter;

    localparam int          T_CYC    = 8;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus, indexed [instance][master]
    logic        d_valid  [2][2];
    logic [31:0] d_addr   [2][2];
    logic [31:0] d_wdata  [2][2];
    logic [3:0]  d_wstrb  [2][2];
    logic [31:0] d_srdata [2];
    logic        d_sready [2];
    logic        d_clr    [2];

    // Observed outputs
    logic        o_ready  [2][2];
    logic [31:0] o_rdata  [2][2];
    logic        o_svalid [2];
    logic [31:0] o_saddr  [2];
    logic [31:0] o_swdata [2];
    logic [3:0]  o_swstrb [2];
    logic [1:0]  o_grant  [2];
    logic        o_tflag  [2];
    logic        o_tmaster[2];

    mem_port_arbiter_if rr_m0 ();
    mem_port_arbiter_if rr_m1 ();
    mem_port_arbiter_if rr_s  ();
    mem_port_arbiter_if fx_m0 ();
    mem_port_arbiter_if fx_m1 ();
    mem_port_arbiter_if fx_s  ();

    assign rr_m0.valid = d_valid[0][0];  assign rr_m0.addr = d_addr[0][0];
    assign rr_m0.wdata = d_wdata[0][0];  assign rr_m0.wstrb = d_wstrb[0][0];
    assign rr_m1.valid = d_valid[0][1];  assign rr_m1.addr = d_addr[0][1];
    assign rr_m1.wdata = d_wdata[0][1];  assign rr_m1.wstrb = d_wstrb[0][1];
    assign fx_m0.valid = d_valid[1][0];  assign fx_m0.addr = d_addr[1][0];
    assign fx_m0.wdata = d_wdata[1][0];  assign fx_m0.wstrb = d_wstrb[1][0];
    assign fx_m1.valid = d_valid[1][1];  assign fx_m1.addr = d_addr[1][1];
    assign fx_m1.wdata = d_wdata[1][1];  assign fx_m1.wstrb = d_wstrb[1][1];
    assign rr_s.rdata  = d_srdata[0];    assign rr_s.ready = d_sready[0];
    assign fx_s.rdata  = d_srdata[1];    assign fx_s.ready = d_sready[1];

    assign o_ready[0][0] = rr_m0.ready;  assign o_rdata[0][0] = rr_m0.rdata;
    assign o_ready[0][1] = rr_m1.ready;  assign o_rdata[0][1] = rr_m1.rdata;
    assign o_ready[1][0] = fx_m0.ready;  assign o_rdata[1][0] = fx_m0.rdata;
    assign o_ready[1][1] = fx_m1.ready;  assign o_rdata[1][1] = fx_m1.rdata;
    assign o_svalid[0] = rr_s.valid;     assign o_saddr[0] = rr_s.addr;
    assign o_swdata[0] = rr_s.wdata;     assign o_swstrb[0] = rr_s.wstrb;
    assign o_svalid[1] = fx_s.valid;     assign o_saddr[1] = fx_s.addr;
    assign o_swdata[1] = fx_s.wdata;     assign o_swstrb[1] = fx_s.wstrb;

    mem_port_arbiter #(
        .PRIORITY_MODE (0),
        .TIMEOUT_CYCLES(T_CYC),
        .ERR_RDATA     (ERR_WORD)
    ) u_dut_rr (
        .clk           (clk),
        .resetn        (resetn),
        .m0            (rr_m0),
        .m1            (rr_m1),
        .s             (rr_s),
        .grant         (o_grant[0]),
        .timeout_flag  (o_tflag[0]),
        .timeout_master(o_tmaster[0]),
        .timeout_clr   (d_clr[0])
    );

    mem_port_arbiter #(
        .PRIORITY_MODE (1),
        .TIMEOUT_CYCLES(T_CYC),
        .ERR_RDATA     (ERR_WORD)
    ) u_dut_fx (
        .clk           (clk),
        .resetn        (resetn),
        .m0            (fx_m0),
        .m1            (fx_m1),
        .s             (fx_s),
        .grant         (o_grant[1]),
        .timeout_flag  (o_tflag[1]),
        .timeout_master(o_tmaster[1]),
        .timeout_clr   (d_clr[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                d_valid[k][m] = 1'b0;
                d_addr[k][m]  = '0;
                d_wdata[k][m] = '0;
                d_wstrb[k][m] = '0;
            end
            d_srdata[k] = '0;
            d_sready[k] = 1'b0;
            d_clr[k]    = 1'b0;
        end
    endtask

    // Leaves the bench 1 time unit after the first live clock edge.
    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    // Answers every grant one cycle after it appears and records the owner order.
    task automatic serve(input int k, input int n, input logic [1:0] drop,
                         output int seq [4], output int got);
        got = 0;
        for (int i = 0; i < 4; i++) seq[i] = -1;
        for (int c = 0; c < 100 && got < n; c++) begin
            @(negedge clk);
            if (o_grant[k] != 2'b00) begin
                seq[got] = (o_grant[k] == 2'b10) ? 1 : 0;
                got++;
                tick();
                d_sready[k] = 1'b1;
                d_srdata[k] = $urandom;
                tick();
                d_sready[k] = 1'b0;
                if (got == n) begin
                    if (drop[0]) d_valid[k][0] = 1'b0;
                    if (drop[1]) d_valid[k][1] = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        d_valid[0][0] = 1'b1;
        d_valid[1][1] = 1'b1;
        d_sready[0]   = 1'b1;
        d_sready[1]   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic [6:0] obs;
            obs = {o_grant[k], o_svalid[k], o_ready[k][0], o_ready[k][1], o_tflag[k], o_tmaster[k]};
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset_ctrl inst%0d: got %b, want 0000000", k, obs);
            end
            checks++;
            if (o_rdata[k][0] !== 32'h0 || o_rdata[k][1] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata inst%0d: got %h/%h, want 0/0", k, o_rdata[k][0], o_rdata[k][1]);
            end
        end
    endtask

    task automatic test_single_read();
        do_reset();
        d_valid[0][0] = 1'b1;
        d_addr[0][0]  = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if ({o_grant[0], o_svalid[0]} !== 3'b000) begin
            errors++;
            $display("FAIL read_T_idle: got %b, want 000", {o_grant[0], o_svalid[0]});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({o_grant[0], o_svalid[0], o_ready[0][0]} !== 4'b0110 || o_saddr[0] !== 32'h0000_0100) begin
            errors++;
            $display("FAIL read_T1_grant: got %b addr %h, want 0110 addr 00000100",
                     {o_grant[0], o_svalid[0], o_ready[0][0]}, o_saddr[0]);
        end
        tick();
        d_sready[0] = 1'b1;
        d_srdata[0] = 32'hA5A5_0001;
        @(negedge clk);
        checks++;
        if ({o_ready[0][0], o_ready[0][1]} !== 2'b10 || o_rdata[0][0] !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL read_T2_ready: got %b rdata %h, want 10 rdata a5a50001",
                     {o_ready[0][0], o_ready[0][1]}, o_rdata[0][0]);
        end
        tick();
        d_valid[0][0] = 1'b0;
        d_sready[0]   = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_grant[0], o_ready[0][0]} !== 3'b000) begin
            errors++;
            $display("FAIL read_T3_idle: got %b, want 000", {o_grant[0], o_ready[0][0]});
        end
    endtask

    task automatic test_round_robin();
        int seq [4];
        int got;
        int want [4];
        want = '{0, 1, 0, 1};
        do_reset();
        d_valid[0][0] = 1'b1;
        d_valid[0][1] = 1'b1;
        serve(0, 4, 2'b11, seq, got);
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, want 4", got);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq[i] !== want[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got master %0d, want %0d", i, seq[i], want[i]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        int seq [4];
        int got;
        do_reset();
        d_valid[1][0] = 1'b1;
        d_valid[1][1] = 1'b1;
        serve(1, 3, 2'b01, seq, got);
        checks++;
        if (got !== 3 || seq[0] !== 0 || seq[1] !== 0 || seq[2] !== 0) begin
            errors++;
            $display("FAIL fixed_m0_wins: got %0d grants order %0d%0d%0d, want 3 order 000",
                     got, seq[0], seq[1], seq[2]);
        end
        serve(1, 1, 2'b10, seq, got);
        checks++;
        if (got !== 1 || seq[0] !== 1) begin
            errors++;
            $display("FAIL fixed_m1_after_idle: got %0d grants first %0d, want 1 first 1", got, seq[0]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        d_valid[0][1] = 1'b1;
        d_addr[0][1]  = 32'h0000_0200;
        tick();
        for (int i = 0; i < T_CYC; i++) begin
            @(negedge clk);
            checks++;
            if ({o_ready[0][1], o_svalid[0]} !== 2'b01) begin
                errors++;
                $display("FAIL tmo_wait[%0d]: got ready/svalid %b, want 01", i, {o_ready[0][1], o_svalid[0]});
            end
            tick();
        end
        d_clr[0] = 1'b1;          // clear in the completion cycle: the set must win
        @(negedge clk);
        checks++;
        if ({o_ready[0][1], o_svalid[0], o_tflag[0]} !== 3'b100 || o_rdata[0][1] !== ERR_WORD) begin
            errors++;
            $display("FAIL tmo_complete: got ready/svalid/flag %b rdata %h, want 100 rdata %h",
                     {o_ready[0][1], o_svalid[0], o_tflag[0]}, o_rdata[0][1], ERR_WORD);
        end
        tick();
        d_valid[0][1] = 1'b0;
        d_clr[0]      = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_tflag[0], o_tmaster[0], o_grant[0]} !== 4'b1100) begin
            errors++;
            $display("FAIL tmo_status: got flag/master/grant %b, want 1100",
                     {o_tflag[0], o_tmaster[0], o_grant[0]});
        end
        tick();
        d_clr[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (o_tflag[0] !== 1'b1) begin
            errors++;
            $display("FAIL tmo_clr_sync: got flag %b before edge, want 1", o_tflag[0]);
        end
        tick();
        d_clr[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (o_tflag[0] !== 1'b0) begin
            errors++;
            $display("FAIL tmo_cleared: got flag %b, want 0", o_tflag[0]);
        end
    endtask

    task automatic test_last_cycle_ready();
        do_reset();
        d_valid[0][0] = 1'b1;
        d_addr[0][0]  = 32'h0000_0300;
        d_wdata[0][0] = 32'hCAFE_F00D;
        d_wstrb[0][0] = 4'hF;
        tick();
        @(negedge clk);
        checks++;
        if (o_swdata[0] !== 32'hCAFE_F00D || o_swstrb[0] !== 4'hF || o_saddr[0] !== 32'h0000_0300) begin
            errors++;
            $display("FAIL edge_write_bus: got %h/%h/%h, want 00000300/cafef00d/f",
                     o_saddr[0], o_swdata[0], o_swstrb[0]);
        end
        repeat (T_CYC - 1) tick();
        d_sready[0] = 1'b1;
        d_srdata[0] = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (o_ready[0][0] !== 1'b1 || o_rdata[0][0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL edge_ready: got ready %b rdata %h, want 1 rdata 12345678",
                     o_ready[0][0], o_rdata[0][0]);
        end
        tick();
        d_valid[0][0] = 1'b0;
        d_sready[0]   = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_tflag[0], o_grant[0], o_ready[0][0]} !== 4'b0000) begin
            errors++;
            $display("FAIL edge_no_timeout: got flag/grant/ready %b, want 0000",
                     {o_tflag[0], o_grant[0], o_ready[0][0]});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_valid[0][0] = 1'b1;
        d_addr[0][0]  = 32'h0000_0400;
        d_wstrb[0][0] = 4'h3;
        tick();
        @(negedge clk);
        checks++;
        if ({o_grant[0], o_svalid[0]} !== 3'b011) begin
            errors++;
            $display("FAIL rstmid_granted: got %b, want 011", {o_grant[0], o_svalid[0]});
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({o_grant[0], o_svalid[0], o_ready[0][0]} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_immediate: got %b, want 0000", {o_grant[0], o_svalid[0], o_ready[0][0]});
        end
        d_sready[0] = 1'b1;
        #1;
        checks++;
        if (o_ready[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_ready: got %b, want 0", o_ready[0][0]);
        end
        do_reset();
    endtask

    task automatic test_random();
        int owner [2];
        int age   [2];
        int last  [2];
        bit err   [2];
        bit flag  [2];
        bit tmast [2];
        bit pend  [2][2];
        bit done_prev [2][2];
        do_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            age[k]   = 0;
            last[k]  = 1;
            err[k]   = 1'b0;
            flag[k]  = 1'b0;
            tmast[k] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                pend[k][m]      = 1'b0;
                done_prev[k][m] = 1'b0;
            end
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            // Masters hold a request until its completion; slave answers and clears are random.
            for (int k = 0; k < 2; k++) begin
                for (int m = 0; m < 2; m++) begin
                    if (done_prev[k][m]) pend[k][m] = 1'b0;
                    if (!pend[k][m] && $urandom_range(0, 2) == 0) begin
                        pend[k][m]    = 1'b1;
                        d_addr[k][m]  = $urandom;
                        d_wdata[k][m] = $urandom;
                        d_wstrb[k][m] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                    end
                    d_valid[k][m] = pend[k][m];
                end
                d_sready[k] = ($urandom_range(0, 4) == 0);
                d_srdata[k] = $urandom;
                d_clr[k]    = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [1:0]  e_grant;
                logic        e_sv;
                logic        e_rdy [2];
                logic [31:0] e_rd  [2];
                logic [6:0]  e_ctrl;
                logic [6:0]  o_ctrl;
                e_grant = (owner[k] < 0) ? 2'b00 : ((owner[k] == 1) ? 2'b10 : 2'b01);
                e_sv    = (owner[k] >= 0) && !err[k] && d_valid[k][owner[k]];
                for (int m = 0; m < 2; m++) begin
                    e_rdy[m] = (owner[k] == m) && (err[k] || d_sready[k]);
                    e_rd[m]  = '0;
                    if (owner[k] == m) e_rd[m] = err[k] ? ERR_WORD : d_srdata[k];
                end
                e_ctrl = {e_grant, e_sv, e_rdy[0], e_rdy[1], flag[k], tmast[k]};
                o_ctrl = {o_grant[k], o_svalid[k], o_ready[k][0], o_ready[k][1], o_tflag[k], o_tmaster[k]};
                checks++;
                if (o_ctrl !== e_ctrl) begin
                    errors++;
                    $display("FAIL rand_ctrl inst%0d cyc%0d: got %b, want %b (grant,sv,rdy0,rdy1,flag,tm)",
                             k, cyc, o_ctrl, e_ctrl);
                end
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if (o_rdata[k][m] !== e_rd[m]) begin
                        errors++;
                        $display("FAIL rand_rdata inst%0d m%0d cyc%0d: got %h, want %h",
                                 k, m, cyc, o_rdata[k][m], e_rd[m]);
                    end
                    done_prev[k][m] = e_rdy[m];
                end
                if (owner[k] >= 0 && !err[k]) begin
                    checks++;
                    if ({o_saddr[k], o_swdata[k], o_swstrb[k]} !==
                        {d_addr[k][owner[k]], d_wdata[k][owner[k]], d_wstrb[k][owner[k]]}) begin
                        errors++;
                        $display("FAIL rand_bus inst%0d cyc%0d: got %h/%h/%h, want %h/%h/%h", k, cyc,
                                 o_saddr[k], o_swdata[k], o_swstrb[k],
                                 d_addr[k][owner[k]], d_wdata[k][owner[k]], d_wstrb[k][owner[k]]);
                    end
                end
            end
            @(posedge clk);
            // Model update from the values present at this edge.
            for (int k = 0; k < 2; k++) begin
                if (err[k]) begin
                    flag[k]  = 1'b1;
                    tmast[k] = (owner[k] == 1);
                    last[k]  = owner[k];
                    owner[k] = -1;
                    err[k]   = 1'b0;
                end else begin
                    if (d_clr[k]) flag[k] = 1'b0;
                    if (owner[k] >= 0) begin
                        if (d_sready[k]) begin
                            last[k]  = owner[k];
                            owner[k] = -1;
                        end else if (age[k] == T_CYC - 1) begin
                            err[k] = 1'b1;
                        end else begin
                            age[k]++;
                        end
                    end else if (d_valid[k][0] || d_valid[k][1]) begin
                        if (d_valid[k][0] && d_valid[k][1]) owner[k] = (k == 1) ? 0 : 1 - last[k];
                        else                                owner[k] = d_valid[k][0] ? 0 : 1;
                        age[k] = 0;
                    end
                end
            end
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: bench stalled before its summary, errors so far %0d", errors);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_last_cycle_ready();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
